alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that computes one WIDTH-bit ALU operation with a single 1-bit ALU slice (alu1b) over WIDTH clock cycles.
- Latches the operands and selects the slice's one-hot ctrl word.
- Feeds operand bits LSB-first, recirculates the carry through a flop, and shifts the slice output into a result register.
- Sits between the CPU decode/issue stage and the shared slice; the slice is instantiated outside this block and wired to its s_* ports.

---
 rtl/alu_serial_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial_ctrl
//  Purpose  : Bit-serial sequencer that computes one WIDTH-bit ALU operation
//             using an external 1-bit ALU slice over WIDTH clock cycles.
//             Operands are fed LSB-first and the carry recirculates through
//             a flop. The slice output is shifted into a result register.
//  Options  : ALU_CARRY_CHAIN_EN adds carry_in plus the ADC (8) and SBB (9) ops.
//  Revision : 1.0  initial release
// ============================================================================
module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef ALU_CARRY_CHAIN_EN
  input  logic             carry_in,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic [8:0]       s_ctrl,
  output logic             s_a,
  output logic             s_b,
  output logic             s_ci,
  output logic             s_ri,
  input  logic             s_q,
  input  logic             s_co
);

  // Slice control words: bit8 B, 7 NOTB, 6 SHR, 5 SHL, 4 NOR, 3 OR, 2 AND, 1 SUM, 0 XOR
  localparam logic [8:0] CTRL_ADD = 9'h102;
  localparam logic [8:0] CTRL_SUB = 9'h182;
  localparam logic [8:0] CTRL_AND = 9'h104;
  localparam logic [8:0] CTRL_OR  = 9'h108;
  localparam logic [8:0] CTRL_NOR = 9'h110;
  localparam logic [8:0] CTRL_XOR = 9'h101;
  localparam logic [8:0] CTRL_SHL = 9'h020;
  localparam logic [8:0] CTRL_SHR = 9'h040;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry_ff;
  logic [8:0]       ctrl_r;
  logic             cvalid_r;  // op reports a carry (ADD/SUB/SHL/ADC/SBB)
  logic             err_flag;  // current request carried an illegal op

  logic             dec_legal;
  logic [8:0]       dec_ctrl;
  logic             dec_cinit;
  logic             dec_cvalid;
  logic             last_cycle;

  assign last_cycle = (cnt == LAST_BIT);

  // Opcode decode: slice control word, initial carry and carry-valid flag
  always_comb begin
    dec_legal  = 1'b1;
    dec_ctrl   = 9'h000;
    dec_cinit  = 1'b0;
    dec_cvalid = 1'b0;
    case (op)
      4'd0: begin dec_ctrl = CTRL_ADD; dec_cvalid = 1'b1; end
      4'd1: begin dec_ctrl = CTRL_SUB; dec_cvalid = 1'b1; dec_cinit = 1'b1; end
      4'd2: dec_ctrl = CTRL_AND;
      4'd3: dec_ctrl = CTRL_OR;
      4'd4: dec_ctrl = CTRL_NOR;
      4'd5: dec_ctrl = CTRL_XOR;
      4'd6: begin dec_ctrl = CTRL_SHL; dec_cvalid = 1'b1; end
      4'd7: dec_ctrl = CTRL_SHR;
`ifdef ALU_CARRY_CHAIN_EN
      4'd8: begin dec_ctrl = CTRL_ADD; dec_cvalid = 1'b1; dec_cinit = carry_in; end
      4'd9: begin dec_ctrl = CTRL_SUB; dec_cvalid = 1'b1; dec_cinit = carry_in; end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: illegal ops skip RUN and report straight from DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = dec_legal ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_cycle) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice drive: everything is forced to zero outside RUN so the slice idles
  always_comb begin
    busy   = (state == RUN);
    s_ctrl = 9'h000;
    s_a    = 1'b0;
    s_b    = 1'b0;
    s_ci   = 1'b0;
    s_ri   = 1'b0;
    if (state == RUN) begin
      s_ctrl = ctrl_r;
      s_a    = a_sh[0];
      s_b    = b_sh[0];
      s_ci   = carry_ff;
      // Zero fill on the final bit makes SHR logical
      s_ri   = last_cycle ? 1'b0 : a_sh[1];
    end
  end

  // Datapath: operand latch, bit-serial shifting and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry_ff  <= 1'b0;
      ctrl_r    <= 9'h000;
      cvalid_r  <= 1'b0;
      err_flag  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      // Completion flags are registered out of DONE, together with result
      done <= (state == DONE);
      err  <= (state == DONE) && err_flag;
      case (state)
        IDLE: begin
          if (start) begin
            err_flag <= ~dec_legal;
            if (dec_legal) begin
              a_sh     <= a_in;
              b_sh     <= b_in;
              res_sh   <= '0;
              cnt      <= '0;
              carry_ff <= dec_cinit;
              ctrl_r   <= dec_ctrl;
              cvalid_r <= dec_cvalid;
            end
          end
        end
        RUN: begin
          a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh   <= {s_q, res_sh[WIDTH-1:1]};
          carry_ff <= s_co;
          cnt      <= cnt + CNT_W'(1);
        end
        DONE: begin
          // An illegal op leaves the previous result and flags untouched
          if (!err_flag) begin
            result    <= res_sh;
            zero      <= (res_sh == '0);
            carry_out <= cvalid_r & carry_ff;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_serial_ctrl
//  Purpose  : Self-checking bench for alu_serial_ctrl with a behavioural
//             1-bit ALU slice attached to the s_* ports. Expected results
//             come from a word-level arithmetic model and go through a queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_serial_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic [8:0]   s_ctrl;
  logic         s_a, s_b, s_ci, s_ri;
  logic         s_q, s_co;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  logic [W-1:0] prev_result;
  logic         prev_carry;
  logic         prev_zero;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
`ifdef ALU_CARRY_CHAIN_EN
    .carry_in  (carry_in),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .s_ctrl    (s_ctrl),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_ci      (s_ci),
    .s_ri      (s_ri),
    .s_q       (s_q),
    .s_co      (s_co)
  );

  // Behavioural alu1b slice
  logic bb;
  assign bb   = s_ctrl[8] & (s_b ^ s_ctrl[7]);
  assign s_q  = (s_ctrl[0] & (s_a ^ bb)) | (s_ctrl[1] & (s_a ^ bb ^ s_ci)) |
                (s_ctrl[2] & s_a & bb) | (s_ctrl[3] & (s_a | bb)) |
                (s_ctrl[4] & ~(s_a | bb)) | (s_ctrl[5] & s_ci) | (s_ctrl[6] & s_ri);
  assign s_co = (s_ctrl[1] & ((s_a & bb) | (s_a & s_ci) | (bb & s_ci))) |
                (s_ctrl[5] & s_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The slice must be idle whenever the sequencer is not running
  always @(negedge clk) begin
    if (!rst && !busy) begin
      n_vec++;
      if (s_ctrl !== 9'h000) begin
        n_err++;
        $display("FAIL idle_ctrl s_ctrl=%h required 000 at %0t", s_ctrl, $time);
      end
    end
  end

  // Word-level reference model
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
    exp_t       e;
    logic [W:0] s;
    logic       c0;
    c0 = (o == 4'd8 || o == 4'd9) ? ci : (o == 4'd1);
    s  = {1'b0, a} + {1'b0, (o[0] ? ~b : b)} + {{W{1'b0}}, c0};
    e  = '0;
    case (o)
      4'd0, 4'd1: begin e.result = s[W-1:0]; e.carry = s[W]; end
`ifdef ALU_CARRY_CHAIN_EN
      4'd8, 4'd9: begin e.result = s[W-1:0]; e.carry = s[W]; end
`endif
      4'd2: e.result = a & b;
      4'd3: e.result = a | b;
      4'd4: e.result = ~(a | b);
      4'd5: e.result = a ^ b;
      4'd6: begin e.result = a << 1; e.carry = a[W-1]; end
      4'd7: e.result = a >> 1;
      default: begin
        e.result = prev_result;
        e.carry  = prev_carry;
        e.zero   = prev_zero;
        e.err    = 1'b1;
        return e;
      end
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Drive one start pulse and push its expectation; returns at the negedge
  // after the sampling edge, with the inputs scrambled
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci);
    exp_t e;
    e = model(o, a, b, ci);
    sb.push_back(e);
    prev_result = e.result;
    prev_carry  = e.carry;
    prev_zero   = e.zero;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; carry_in = ci;
    @(negedge clk);
    start = 1'b0;
    op    = 4'($urandom_range(0, 15));
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    carry_in = 1'($urandom);
  endtask

  // Bounded wait for done (no checking here)
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, err, result, carry_out, zero, s_ctrl, s_a, s_b, s_ci, s_ri} !== '0) begin
      n_err++;
      $display("FAIL reset busy=%b done=%b err=%b result=%h c=%b z=%b ctrl=%h s=%b%b%b%b required all 0",
               busy, done, err, result, carry_out, zero, s_ctrl, s_a, s_b, s_ci, s_ri);
    end
    rst = 1'b0;
    prev_result = '0; prev_carry = 1'b0; prev_zero = 1'b0;
  endtask

  // ADD 0x7F+0x01 with cycle-exact latency and ctrl word checks
  task automatic test_latency;
    exp_t e;
    issue(4'd0, 8'h7F, 8'h01, 1'b0);
    for (int i = 0; i < W; i++) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0 || s_ctrl !== 9'h102) begin
        n_err++;
        $display("FAIL lat_run[%0d] busy=%b done=%b ctrl=%h required 1 0 102", i, busy, done, s_ctrl);
      end
      @(negedge clk);
    end
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL lat_donestate busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (done !== 1'b1 || {result, carry_out, zero, err} !== e) begin
      n_err++;
      $display("FAIL lat_done done=%b result=%h c=%b z=%b err=%b required 1 %h %b %b %b",
               done, result, carry_out, zero, err, e.result, e.carry, e.zero, e.err);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL lat_pulse done=%b required 0", done);
    end
  endtask

  // SUB, shifts and logic ops, issued back to back
  task automatic test_alu_ops;
    logic [3:0]   ops [10] = '{4'd1, 4'd1, 4'd6, 4'd7, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd6};
    logic [W-1:0] as  [10] = '{8'h05, 8'h03, 8'h81, 8'h81, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'hC8, 8'h40};
    logic [W-1:0] bs  [10] = '{8'h05, 8'h05, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h0C, 8'hFF, 8'h64, 8'h00};
    exp_t e;
    bit   ok;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], 1'b0);
      wait_done(ok);
      e = sb.pop_front();
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL ops[%0d] no done within bound", i);
      end else if ({result, carry_out, zero, err} !== e) begin
        n_err++;
        $display("FAIL ops[%0d] op=%0d result=%h c=%b z=%b err=%b required %h %b %b %b",
                 i, ops[i], result, carry_out, zero, err, e.result, e.carry, e.zero, e.err);
      end
    end
  endtask

  // Illegal opcode: err with done, result and flags unchanged
  task automatic test_illegal;
    exp_t e;
    bit   ok;
    issue(4'hF, 8'h12, 8'h34, 1'b0);
    wait_done(ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || {result, carry_out, zero, err} !== e) begin
      n_err++;
      $display("FAIL illegal ok=%b result=%h c=%b z=%b err=%b required %h %b %b 1",
               ok, result, carry_out, zero, err, e.result, e.carry, e.zero);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_pulse done=%b err=%b required 0 0", done, err);
    end
  endtask

  // A start during RUN is dropped: correct first result, no second done
  task automatic test_ignore_start;
    exp_t e;
    bit   ok;
    int   extra;
    issue(4'd0, 8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 4'd1; a_in = 8'hFF; b_in = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    e = sb.pop_front();
    n_vec++;
    if (!ok || {result, carry_out, zero, err} !== e) begin
      n_err++;
      $display("FAIL ignore ok=%b result=%h c=%b z=%b err=%b required %h %b %b %b",
               ok, result, carry_out, zero, err, e.result, e.carry, e.zero, e.err);
    end
    extra = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL ignore_extra done_pulses=%0d required 0", extra);
    end
  endtask

  // Reset in the fourth RUN cycle aborts without done and clears result
  task automatic test_reset_mid_run;
    int seen;
    issue(4'd0, 8'h55, 8'h11, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || result !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midrst busy=%b result=%h done=%b required 0 00 0", busy, result, done);
    end
    prev_result = '0; prev_carry = 1'b0; prev_zero = 1'b0;
    seen = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL midrst_done done_pulses=%0d required 0", seen);
    end
  endtask

`ifdef ALU_CARRY_CHAIN_EN
  // ADC / SBB with an external carry-in
  task automatic test_carry_chain;
    logic [3:0]   ops [4] = '{4'd8, 4'd9, 4'd8, 4'd9};
    logic [W-1:0] as  [4] = '{8'hFF, 8'h10, 8'h10, 8'h00};
    logic [W-1:0] bs  [4] = '{8'h00, 8'h01, 8'h20, 8'h00};
    logic         cs  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_t e;
    bit   ok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], cs[i]);
      wait_done(ok);
      e = sb.pop_front();
      n_vec++;
      if (!ok || {result, carry_out, zero, err} !== e) begin
        n_err++;
        $display("FAIL chain[%0d] ok=%b result=%h c=%b z=%b err=%b required %h %b %b %b",
                 i, ok, result, carry_out, zero, err, e.result, e.carry, e.zero, e.err);
      end
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a_in  = '0;
    b_in  = '0;
    carry_in = 1'b0;
    test_reset;
    test_latency;
    test_alu_ops;
    test_illegal;
    test_ignore_start;
    test_reset_mid_run;
    test_alu_ops;
`ifdef ALU_CARRY_CHAIN_EN
    test_carry_chain;
`endif
    test_illegal;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
